// File: rtl/fifo_ctrl_arb.sv
// fifo_ctrl_arb: round-robin write arbiter and read sequencer around a shared FIFO, with 2-entry output skid buffer
//   requesters : req_valid/req_data in, req_ready (one-hot grant) and grant_id out
//   fifo side  : fifo_din/fifo_wr/fifo_rd/fifo_en out, fifo_dout/fifo_empty/fifo_full in
//   consumer   : out_valid/out_data out, out_ready in
//   rst is asynchronous active-low
module fifo_ctrl_arb #(
  parameter int NREQ = 4,
  parameter int DWIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DWIDTH-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic [DWIDTH-1:0]        fifo_din,
  output logic                     fifo_wr,
  output logic                     fifo_rd,
  output logic                     fifo_en,
  input  logic [DWIDTH-1:0]        fifo_dout,
  input  logic                     fifo_empty,
  input  logic                     fifo_full,
  output logic                     out_valid,
  output logic [DWIDTH-1:0]        out_data,
  input  logic                     out_ready
);
  localparam int GW = $clog2(NREQ);
  logic [GW-1:0] rr_ptr, winner, idx;
  logic [1:0] occ;
  logic inflight, pop;
  logic [DWIDTH-1:0] skid0, skid1;
  // descending scan so the candidate nearest rr_ptr is assigned last and wins
  always_comb begin
    winner = '0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = GW'((int'(rr_ptr) + k) % NREQ);
      winner = req_valid[idx] ? idx : winner;
    end
  end
  assign fifo_wr   = rst & enable & ~fifo_full & (|req_valid);
  assign req_ready = {{(NREQ-1){1'b0}}, fifo_wr} << winner;
  assign grant_id  = fifo_wr ? winner : '0;
  assign fifo_din  = rst ? req_data[winner*DWIDTH +: DWIDTH] : '0;
  assign out_valid = occ != 2'd0;
  assign out_data  = skid0;
  assign pop       = out_valid & out_ready;
  // a read is only issued when its data is guaranteed a skid slot next cycle
  assign fifo_rd   = rst & enable & ~fifo_empty & ({1'b0, occ} + {2'b0, inflight} < 3'd2 + {2'b0, pop});
  assign fifo_en   = fifo_wr | fifo_rd;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr   <= '0;
      inflight <= 1'b0;
      occ      <= 2'd0;
      skid0    <= '0;
      skid1    <= '0;
    end else begin
      if (fifo_wr) rr_ptr <= (winner == GW'(NREQ - 1)) ? '0 : winner + 1'b1;
      inflight <= fifo_rd;
      occ <= occ + {1'b0, inflight} - {1'b0, pop};
      if (pop) skid0 <= skid1;
      // returning read data lands in the first slot left free after this cycle's pop
      if (inflight && occ == {1'b0, pop}) skid0 <= fifo_dout;
      if (inflight && occ != {1'b0, pop}) skid1 <= fifo_dout;
    end
  end
  assert property (@(posedge clk) disable iff (!rst) ({1'b0, occ} + {2'b0, inflight} <= 3'd2));
endmodule

// File: tb/tb_fifo_ctrl_arb.sv
// tb_fifo_ctrl_arb: randomized and directed self-checking bench against a queue-based reference model
module tb_fifo_ctrl_arb;
  localparam int N = 4;
  localparam int W = 8;
  localparam int DEPTH = 8;
  logic clk = 0, rst = 1, enable = 0, out_ready = 0;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*W-1:0] req_data = '0;
  logic [1:0] grant_id;
  logic [W-1:0] fifo_din, fifo_dout, out_data;
  logic fifo_wr, fifo_rd, fifo_en, fifo_empty, fifo_full, out_valid;
  fifo_ctrl_arb #(.NREQ(N), .DWIDTH(W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .grant_id(grant_id), .fifo_din(fifo_din), .fifo_wr(fifo_wr),
    .fifo_rd(fifo_rd), .fifo_en(fifo_en), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );
  always #5 clk = ~clk;
  logic [W-1:0] fmem [DEPTH];
  int fwp = 0, frp = 0, fcnt = 0;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwp <= 0;
      frp <= 0;
      fcnt <= 0;
      fifo_dout <= '0;
    end else begin
      if (fifo_wr && fifo_en && fcnt < DEPTH) begin
        fmem[fwp] <= fifo_din;
        fwp <= (fwp + 1) % DEPTH;
      end
      if (fifo_rd && fifo_en && fcnt > 0) begin
        fifo_dout <= fmem[frp];
        frp <= (frp + 1) % DEPTH;
      end
      fcnt <= fcnt + int'(fifo_wr && fifo_en && fcnt < DEPTH) - int'(fifo_rd && fifo_en && fcnt > 0);
    end
  end
  assign fifo_empty = fcnt == 0;
  assign fifo_full = fcnt == DEPTH;
  int tests = 0, fails = 0;
  int rr = 0, cnt [N];
  bit infl = 0;
  logic [W-1:0] skq [$], sb [$], popped [$];
  logic rst_v = 1, en_v = 0, ordy_v = 0, ovr = 0;
  logic [N-1:0] rv = '0;
  logic [W-1:0] ovr_val = '0;
  logic [N-1:0] s_ready;
  logic [1:0] s_gid;
  logic s_wr, s_rd, s_en, s_ov, s_full;
  logic [W-1:0] s_od;
  int s_fcnt;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  function automatic logic [W-1:0] word(input int i);
    return (ovr && i == 0) ? ovr_val : {4'(i), 4'(cnt[i] + 1)};
  endfunction
  task automatic step();
    int win;
    bit ewr, erd, ov, pop;
    logic [W-1:0] dv, wd;
    @(negedge clk);
    rst = rst_v;
    req_valid = rv;
    enable = en_v;
    out_ready = ordy_v;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = word(i);
    #1;
    s_ready = req_ready; s_gid = grant_id; s_wr = fifo_wr; s_rd = fifo_rd; s_en = fifo_en;
    s_ov = out_valid; s_od = out_data; s_full = fifo_full; s_fcnt = fcnt;
    if (!rst) begin
      chk("rst_comb", {req_ready, grant_id, fifo_wr, fifo_rd, fifo_en, fifo_din}, 0);
      chk("rst_out", {out_valid, out_data}, 0);
      rr = 0; infl = 0; skq.delete(); sb.delete(); popped.delete();
      foreach (cnt[i]) cnt[i] = 0;
      @(posedge clk);
      return;
    end
    win = 0;
    for (int k = N - 1; k >= 0; k--) if (rv[(rr + k) % N]) win = (rr + k) % N;
    ewr = en_v && !fifo_full && (rv != 0);
    ov = skq.size() > 0;
    pop = ov && ordy_v;
    erd = en_v && !fifo_empty && (skq.size() + int'(infl) - int'(pop) < 2);
    wd = word(win);
    chk("req_ready", req_ready, ewr ? (1 << win) : 0);
    chk("grant_id", grant_id, ewr ? win : 0);
    chk("fifo_wr", fifo_wr, ewr);
    chk("fifo_rd", fifo_rd, erd);
    chk("fifo_en", fifo_en, ewr | erd);
    if (ewr) chk("fifo_din", fifo_din, wd);
    chk("out_valid", out_valid, ov);
    if (ov) chk("out_data", out_data, skq[0]);
    if (pop) begin
      chk("order", out_data, sb.size() > 0 ? sb[0] : 'x);
      popped.push_back(out_data);
    end
    dv = fifo_dout;
    @(posedge clk);
    if (pop) begin
      void'(skq.pop_front());
      if (sb.size() > 0) void'(sb.pop_front());
    end
    if (infl) skq.push_back(dv);
    infl = erd;
    if (ewr) begin
      sb.push_back(wd);
      rr = (win + 1) % N;
      cnt[win]++;
    end
  endtask
  task automatic do_reset();
    rst_v = 0;
    step();
    rst_v = 1;
  endtask
  initial begin
    logic [W-1:0] exp_fair [4];
    logic [3:0] bp_pat;
    exp_fair = '{8'h11, 8'h31, 8'h12, 8'h32};
    bp_pat = 4'b1001;
    rv = '1;
    do_reset();
    chk("reset_ready", s_ready, 0);
    chk("reset_en", s_en, 0);
    chk("reset_ov", s_ov, 0);
    en_v = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("reset_rr_gid", s_gid, i % N);
      chk("reset_rr_wr", s_wr, 1);
    end
    do_reset();
    rv = 4'b1010; ordy_v = 1;
    for (int i = 0; i < 20 && popped.size() < 4; i++) step();
    chk("fair_count", popped.size(), 4);
    for (int i = 0; i < 4; i++) chk("fair_word", i < popped.size() ? popped[i] : 'x, exp_fair[i]);
    do_reset();
    rv = '1; ordy_v = 0;
    for (int i = 0; i < 14; i++) step();
    chk("full_flag", s_full, 1);
    chk("full_ready", s_ready, 0);
    chk("full_wr", s_wr, 0);
    chk("full_level", s_fcnt, DEPTH);
    chk("full_ov", s_ov, 1);
    chk("full_total", sb.size(), 10);
    rv = '0; ordy_v = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("drain_gap", s_ov, 1);
    end
    step();
    chk("drain_end", s_ov, 0);
    chk("drain_first", popped.size() == 10 ? popped[0] : 'x, 8'h01);
    chk("drain_last", popped.size() == 10 ? popped[9] : 'x, 8'h13);
    do_reset();
    ovr = 1; ovr_val = 8'hA5; rv = 4'b0001; ordy_v = 1;
    step();
    chk("lat_wr", s_wr, 1);
    chk("lat_rd0", s_rd, 0);
    rv = '0;
    step();
    chk("lat_rd1", s_rd, 1);
    step();
    chk("lat_rd2", s_rd, 0);
    chk("lat_ov2", s_ov, 0);
    step();
    chk("lat_ov3", s_ov, 1);
    chk("lat_data", s_od, 8'hA5);
    ovr = 0;
    do_reset();
    rv = 4'b0001;
    for (int i = 0; i < 40 && popped.size() < 6; i++) begin
      ordy_v = bp_pat[i % 4];
      rv = cnt[0] < 6 ? 4'b0001 : 4'b0000;
      step();
    end
    chk("bp_count", popped.size(), 6);
    for (int i = 0; i < 6; i++) chk("bp_word", i < popped.size() ? popped[i] : 'x, i + 1);
    do_reset();
    ordy_v = 0; rv = 4'b0001;
    step();
    rv = '0;
    step();
    chk("dis_rd_issued", s_rd, 1);
    en_v = 0; rv = '1;
    step();
    chk("dis_wr", s_wr, 0);
    chk("dis_rd", s_rd, 0);
    step();
    chk("dis_landed_ov", s_ov, 1);
    chk("dis_landed_data", s_od, 8'h01);
    do_reset();
    chk("async_ov", s_ov, 0);
    chk("async_ready", s_ready, 0);
    en_v = 1; rv = 4'b1001;
    step();
    chk("rr_after_rst", s_gid, 0);
    chk("rr_after_rst_ready", s_ready, 4'b0001);
    for (int i = 0; i < 3000; i++) begin
      rst_v = $urandom_range(0, 299) != 0;
      rv = N'($urandom);
      en_v = $urandom_range(0, 7) != 0;
      ordy_v = $urandom_range(0, 3) != 0;
      step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
